freq_gen: RTL and testbench
===========================

# freq_gen

Programmable square-wave generator; the transmit-side counterpart of the period-averaging frequency detector. It produces `freq_out` with a period and high time given in `clk` cycles, and can run continuously or for a fixed burst of periods. New settings arrive through a one-deep, handshaked configuration slot and take effect only at a period boundary, so the output never glitches. Its output can be looped back into the detector for self-test.

## Interface
- `WIDTH`, 32: width of the period and high-time counters and config fields.
- `BURST_W`, 16: width of the burst length and period counter.
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: run request.
- `period_in`, in, WIDTH: full period in cycles; legal range 2 and above.
- `high_in`, in, WIDTH: high time in cycles; legal range is 1 to `period_in`-1.
- `burst_in`, in, BURST_W: number of periods to generate; 0 means continuous.
- `load_valid`, in, 1: config offer.
- `load_ready`, out, 1: config slot empty; equals `~pending_valid`.
- `cfg_err`, out, 1: one-cycle pulse when an accepted config is illegal.
- `freq_out`, out, 1: generated signal, registered.
- `period_start`, out, 1: one-cycle pulse coincident with each rising edge of `freq_out`.
- `period_count`, out, BURST_W: periods completed since the last activation; wraps.
- `busy`, out, 1: high when the state is not IDLE.
- `done`, out, 1: one-cycle pulse when a burst completes.

## Operation
- **Reset values:** all outputs 0 except `load_ready`=1. The pending and active configs are invalid and the state is IDLE.
- **Load:** the transfer happens on a cycle with `load_valid && load_ready`.
  - A legal config goes to the pending slot.
  - An illegal config is dropped, `cfg_err` pulses the next cycle, and the slot stays empty.
- **Boundary:** a boundary is the transition IDLE→HIGH or LOW→HIGH.
  - At each boundary, a valid pending config moves to the active config and the slot empties.
  - At activation from IDLE, `period_count` clears to 0.
- **States:**
  - IDLE: `freq_out`=0. If `enable` is high and either the active or pending config is valid, go to HIGH.
  - HIGH: counts from 1. When cnt == act_high, go to LOW with cnt=1.
  - LOW: when cnt == act_period−act_high, the period ends and `period_count` increments. Then:
    - If act_burst≠0 and the new count == act_burst: pulse `done`, invalidate the active config, go to IDLE.
    - Otherwise, if `enable`=0: go to IDLE.
    - Otherwise: go to HIGH.
- **Enable deassert:** dropping `enable` mid-period finishes the current period first. The output is never truncated.
- **Restart after burst:** requires a new load, because the active config was invalidated. If a pending config exists at that moment, the next cycle starts it when `enable` is high.
- **Arithmetic:** unsigned WIDTH-bit arithmetic. act_period−act_high cannot underflow because illegal configs are rejected at load.

## Timing
- IDLE with `enable` and a valid config on cycle N: `freq_out`=1 and `period_start`=1 on cycle N+1.
- Output waveform: `freq_out` is high for exactly act_high cycles, then low for exactly act_period−act_high cycles.
- Back-to-back periods in continuous mode have no gap cycles.
- Load on cycle N: `load_ready` drops at N+1. It rises the cycle after the next boundary consumes the slot.
- Simultaneous load and boundary with an empty slot: the boundary uses the old config; the new config waits for the following boundary.
- `done` is asserted on the final LOW cycle's successor, together with `busy` going low.
- `reset` mid-period: on the next cycle, all state returns to reset values and the pending config is discarded.

## Structure
- Package `freq_pkg` holds:
  - the state enum IDLE/HIGH/LOW;
  - `MIN_PERIOD`=2;
  - the config struct {period, high, burst}.
- Sub-module `freq_gen_cfg` contains the legality check, the pending slot and the `load_ready`/`cfg_err` logic. The top level holds the FSM and counters.

## Test plan
- **Continuous run:** load period=10, high=3, burst=0, with `enable`=1. Required: `freq_out` repeats high for 3 cycles, low for 7; `period_start` pulses every 10 cycles; `period_count` increments each period.
- **Burst of 4:** period=5, high=2. Required: exactly 4 periods, then `done` pulses once, `busy`=0 and `freq_out` stays 0 even though `enable` remains 1.
- **Config change mid-run:** running period=8, high=4; load period=4, high=1 mid-high. Required: the current 8-cycle period completes intact, then 1-high/3-low periods follow, and `load_ready` returns to 1 at that boundary.
- **Illegal loads:** load period=1, then high=0, then high=period=6. Required: `cfg_err` pulses three times, `load_ready` stays 1 and the output is unchanged.
- **Enable drop:** running period=6, high=3; drop `enable` on high cycle 2. Required: the period finishes (3 high, 3 low), then IDLE.
- **Reset mid-period:** run, then assert `reset` for 1 cycle. Required: next cycle `freq_out`=0, `busy`=0, `period_count`=0 and `load_ready`=1.

Source files
------------

// File: rtl/freq_pkg.sv
// freq_pkg: shared state, limits and config record for the square-wave generator
package freq_pkg;
    localparam int CFG_W = 32;
    localparam int CFG_BW = 16;
    localparam int MIN_PERIOD = 2;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
    typedef struct packed {
        logic [CFG_W-1:0]  period;
        logic [CFG_W-1:0]  high;
        logic [CFG_BW-1:0] burst;
    } cfg_t;
endpackage

// File: rtl/freq_gen_cfg.sv
// freq_gen_cfg: legality check and one-deep pending config slot
module freq_gen_cfg
    import freq_pkg::*;
#(
    parameter int WIDTH = CFG_W,
    parameter int BURST_W = CFG_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   period_i,
    input  logic [WIDTH-1:0]   high_i,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               load_valid_i,
    input  logic               take_i,
    output logic               load_ready_o,
    output logic               cfg_err_o,
    output logic               pend_valid_o,
    output cfg_t               pend_o
);
    logic legal, accept;
    logic pend_valid_q, pend_valid_d, cfg_err_q;
    cfg_t pend_q, pend_d;

    // take_i only fires while the slot is full, so it never races a new accept
    always_comb begin
        legal = period_i >= WIDTH'(MIN_PERIOD) && high_i != '0 && high_i < period_i;
        accept = load_valid_i && !pend_valid_q;
        pend_valid_d = accept ? legal : pend_valid_q && !take_i;
        pend_d = accept && legal ? '{period: CFG_W'(period_i), high: CFG_W'(high_i), burst: CFG_BW'(burst_i)} : pend_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q <= pend_d;
            cfg_err_q <= accept && !legal;
        end
    end

    assign load_ready_o = !pend_valid_q;
    assign cfg_err_o = cfg_err_q;
    assign pend_valid_o = pend_valid_q;
    assign pend_o = pend_q;
endmodule

// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave generator with burst mode and glitch-free reconfiguration
module freq_gen
    import freq_pkg::*;
#(
    parameter int WIDTH = CFG_W,
    parameter int BURST_W = CFG_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [WIDTH-1:0]   period_in,
    input  logic [WIDTH-1:0]   high_in,
    input  logic [BURST_W-1:0] burst_in,
    input  logic               load_valid,
    output logic               load_ready,
    output logic               cfg_err,
    output logic               freq_out,
    output logic               period_start,
    output logic [BURST_W-1:0] period_count,
    output logic               busy,
    output logic               done
);
    state_e state_q;
    logic [WIDTH-1:0] cnt_q, low_len;
    logic [BURST_W-1:0] period_count_q, pc_inc;
    cfg_t act_q, pend;
    logic act_valid_q, pend_valid, freq_out_q, period_start_q, done_q;
    logic period_end, burst_end, boundary, take;

    freq_gen_cfg #(.WIDTH(WIDTH), .BURST_W(BURST_W)) u_cfg (
        .clk          (clk),
        .reset        (reset),
        .period_i     (period_in),
        .high_i       (high_in),
        .burst_i      (burst_in),
        .load_valid_i (load_valid),
        .take_i       (take),
        .load_ready_o (load_ready),
        .cfg_err_o    (cfg_err),
        .pend_valid_o (pend_valid),
        .pend_o       (pend)
    );

    always_comb begin
        low_len = WIDTH'(act_q.period) - WIDTH'(act_q.high);
        pc_inc = period_count_q + BURST_W'(1);
        period_end = state_q == LOW && cnt_q == low_len;
        burst_end = period_end && act_q.burst != '0 && pc_inc == BURST_W'(act_q.burst);
        boundary = enable && ((state_q == IDLE && (act_valid_q || pend_valid)) || (period_end && !burst_end));
        take = boundary && pend_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            act_q <= '0;
            act_valid_q <= 1'b0;
            freq_out_q <= 1'b0;
            period_start_q <= 1'b0;
            done_q <= 1'b0;
            period_count_q <= '0;
        end else begin
            period_start_q <= 1'b0;
            done_q <= 1'b0;
            if (take) act_q <= pend;
            if (boundary) begin
                state_q <= HIGH;
                cnt_q <= WIDTH'(1);
                freq_out_q <= 1'b1;
                period_start_q <= 1'b1;
                act_valid_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (boundary) period_count_q <= '0;
                HIGH: begin
                    if (cnt_q == WIDTH'(act_q.high)) begin
                        state_q <= LOW;
                        cnt_q <= WIDTH'(1);
                        freq_out_q <= 1'b0;
                    end else cnt_q <= cnt_q + WIDTH'(1);
                end
                LOW: begin
                    if (period_end) begin
                        period_count_q <= pc_inc;
                        if (!boundary) begin
                            state_q <= IDLE;
                            freq_out_q <= 1'b0;
                        end
                        // a finished burst forces a fresh load before the next run
                        if (burst_end) begin
                            done_q <= 1'b1;
                            act_valid_q <= 1'b0;
                        end
                    end else cnt_q <= cnt_q + WIDTH'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign freq_out = freq_out_q;
    assign period_start = period_start_q;
    assign period_count = period_count_q;
    assign busy = state_q != IDLE;
    assign done = done_q;
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: directed checks of waveform shape, bursts, reconfiguration, illegal loads and reset
module tb_freq_gen;
    logic        clk, reset, enable, load_valid;
    logic [31:0] period_in, high_in;
    logic [15:0] burst_in, period_count;
    logic        load_ready, cfg_err, freq_out, period_start, busy, done;
    int n_cmp = 0;
    int n_err = 0;

    freq_gen dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period_in    (period_in),
        .high_in      (high_in),
        .burst_in     (burst_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .cfg_err      (cfg_err),
        .freq_out     (freq_out),
        .period_start (period_start),
        .period_count (period_count),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // i counts cycles from the first high cycle of the current config
    task automatic wave(input int p, input int h, input int i0, input int i1, input int pc0);
        for (int i = i0; i < i1; i++) begin
            chk("freq_out", freq_out, 32'((i % p) < h));
            chk("period_start", period_start, 32'((i % p) == 0));
            chk("period_count", period_count, 32'(pc0 + i / p));
            chk("busy", busy, 1);
            tick();
        end
    endtask

    task automatic set_cfg(input int p, input int h, input int b);
        period_in = p;
        high_in = h;
        burst_in = 16'(b);
        load_valid = 1'b1;
    endtask

    task automatic chk_idle(input string tag, input int pc);
        chk({tag, " freq_out"}, freq_out, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " period_start"}, period_start, 0);
        chk({tag, " period_count"}, period_count, pc);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        load_valid = 1'b0;
        period_in = '0;
        high_in = '0;
        burst_in = '0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset", 0);
        chk("reset load_ready", load_ready, 1);
        chk("reset cfg_err", cfg_err, 0);
        chk("reset done", done, 0);

        // continuous 10/3
        enable = 1'b1;
        set_cfg(10, 3, 0);
        tick();
        load_valid = 1'b0;
        chk("cont load_ready low", load_ready, 0);
        chk("cont not started", freq_out, 0);
        tick();
        chk("cont load_ready back", load_ready, 1);
        wave(10, 3, 0, 30, 0);
        enable = 1'b0;
        wave(10, 3, 30, 40, 0);
        chk_idle("cont stop", 4);

        // burst of 4 at 5/2
        set_cfg(5, 2, 4);
        tick();
        load_valid = 1'b0;
        enable = 1'b1;
        tick();
        wave(5, 2, 0, 20, 0);
        chk("burst done", done, 1);
        chk_idle("burst end", 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("burst done once", done, 0);
            chk_idle("burst after", 4);
        end

        // reconfiguration mid-high: 8/4 then 4/1
        set_cfg(8, 4, 0);
        tick();
        load_valid = 1'b0;
        tick();
        wave(8, 4, 0, 1, 0);
        set_cfg(4, 1, 0);
        wave(8, 4, 1, 2, 0);
        load_valid = 1'b0;
        chk("chg load_ready low", load_ready, 0);
        wave(8, 4, 2, 8, 0);
        chk("chg load_ready back", load_ready, 1);
        wave(4, 1, 0, 12, 1);

        // illegal loads while running 4/1
        for (int k = 0; k < 3; k++) begin
            set_cfg(k == 0 ? 1 : 6, k == 0 ? 1 : (k == 1 ? 0 : 6), 0);
            wave(4, 1, 12 + 2 * k, 13 + 2 * k, 1);
            load_valid = 1'b0;
            chk("bad cfg_err", cfg_err, 1);
            chk("bad load_ready", load_ready, 1);
            wave(4, 1, 13 + 2 * k, 14 + 2 * k, 1);
            chk("bad cfg_err clear", cfg_err, 0);
        end

        // enable drop on high cycle 2 of a 6/3 period
        set_cfg(6, 3, 0);
        wave(4, 1, 18, 19, 1);
        load_valid = 1'b0;
        wave(4, 1, 19, 20, 1);
        wave(6, 3, 0, 1, 6);
        enable = 1'b0;
        wave(6, 3, 1, 6, 6);
        chk_idle("drop", 7);
        tick();
        chk_idle("drop hold", 7);

        // reset mid-period discards pending config
        enable = 1'b1;
        tick();
        wave(6, 3, 0, 2, 0);
        set_cfg(10, 3, 0);
        wave(6, 3, 2, 3, 0);
        load_valid = 1'b0;
        chk("rst pend load_ready", load_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst mid", 0);
        chk("rst load_ready", load_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle("rst after", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
